// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-outstanding register-bus initiator
// Turns one command at a time into a wr_en/rd_en bus cycle and returns exactly one response.
module reg_bus_master #(
  parameter int          RD_LATENCY = 0,
  parameter logic [13:0] ADDR_LO    = 14'h000,
  parameter logic [13:0] ADDR_HI    = 14'h3fff
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [13:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wr_en,
  output logic        rd_en,
  output logic [13:0] addr,
  output logic [15:0] write_data,
  input  logic [15:0] read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_cnt;
  logic [14:0] w_lo_diff;
  logic [14:0] w_hi_diff;
  logic        w_in_range;

  // The borrow bit of a one-bit-wider difference gives the inclusive unsigned bounds check.
  assign w_lo_diff  = {1'b0, cmd_addr} - {1'b0, ADDR_LO};
  assign w_hi_diff  = {1'b0, ADDR_HI} - {1'b0, cmd_addr};
  assign w_in_range = !w_lo_diff[14] && !w_hi_diff[14];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_cnt      <= 2'd0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 16'h0000;
      rsp_err    <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      addr       <= 14'h0000;
      write_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            r_write   <= cmd_write;
            rsp_rdata <= 16'h0000;
            if (w_in_range) begin
              rsp_err    <= 1'b0;
              addr       <= cmd_addr;
              write_data <= cmd_wdata;
              wr_en      <= cmd_write;
              rd_en      <= !cmd_write;
              r_state    <= S_ISSUE;
            end else begin
              // Out-of-range: no strobe and the bus address is left untouched.
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              r_state   <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          wr_en <= 1'b0;
          rd_en <= 1'b0;
          if (r_write) begin
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else if (RD_LATENCY == 0) begin
            rsp_rdata <= read_data;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt   <= 2'(RD_LATENCY);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd1) begin
            rsp_rdata <= read_data;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
